data_mem_resp: RTL and testbench
================================

// Module: data_mem_resp
// PURPOSE
//  Memory-stage responder. Consumes the load/store request held in the EX/MEM pipeline register
//  (MemRead/MemWrite, ALU result as address, rs2 data as store data) and services it against a
//  word-addressed data RAM with a fixed multi-cycle latency.
//  Raises stall_o so the pipeline freezes EX/MEM until the access completes.
//  Returns load data and a one-cycle completion pulse for the MEM/WB register.
// PARAMETERS
//  DEPTH_LOG2  8   log2 of RAM depth in 32-bit words (256 words)
//  LATENCY     4   access latency, in cycles spent in WAIT; legal range 1..15
// PORTS
//  clk_i        in   1   clock, rising edge
//  rst_i        in   1   reset, asynchronous, active-high
//  MemRead_i    in   1   load request from EX/MEM
//  MemWrite_i   in   1   store request from EX/MEM
//  addr_i       in   32  byte address (EX/MEM ALU result)
//  wdata_i      in   32  store data (EX/MEM rs2 data)
//  rdata_o      out  32  load data; valid in the ack_o cycle, held until the next completed load
//  ack_o        out  1   one-cycle pulse: request completed
//  err_o        out  1   one-cycle pulse with ack_o: request illegal, no RAM access done
//  stall_o      out  1   freeze PC/IF/ID/ID-EX/EX-MEM this cycle
// BEHAVIOUR
//  Reset values (async on rst_i=1)
//  - state=IDLE, counter=0, rdata_o=0, ack_o=0, err_o=0.
//  - The RAM array is not cleared by reset; it is zero-initialised at time 0 for simulation.
//  Request and registers
//  - req = MemRead_i | MemWrite_i.
//  - On leaving IDLE, latch op, addr_i and wdata_i; later input changes are ignored.
//  FSM states: IDLE, WAIT, DONE
//  - IDLE: if req, load counter=LATENCY-1, latch request, go to WAIT. Otherwise stay.
//  - WAIT:
//    - counter!=0: decrement the counter.
//    - counter==0: perform the access at this edge, go to DONE.
//  - DONE: ack_o=1 for exactly this cycle; always return to IDLE.
//    - DONE never samples req: the still-present old request must not retrigger.
//  stall_o (combinational)
//  - stall_o = (IDLE & req) | WAIT; it is 0 in DONE.
//  - So stall_o is high for LATENCY+1 cycles per request; ack_o follows in the next cycle.
//  Access
//  - RAM index = latched addr[DEPTH_LOG2+1:2]; upper address bits are ignored, so addresses alias
//    (wrap modulo 4*2^DEPTH_LOG2 bytes).
//  - Load: rdata_o <= RAM[index].
//  - Store: RAM[index] <= latched wdata; rdata_o is unchanged.
//  Illegal requests (complete normally, with err_o=1 in the ack_o cycle)
//  - Misaligned (addr[1:0]!=0): no RAM read/write; a load returns rdata_o=0.
//  - MemRead_i & MemWrite_i both set: treated as illegal; no access; rdata_o unchanged.
//  Back-to-back
//  - After DONE, the pipeline advances at that edge. A new request visible in IDLE stalls
//    immediately, giving no bubble beyond the fixed latency.
//  Reset mid-operation
//  - Return to IDLE; any pending store is discarded and ack_o is not issued.
//  - After deassert, a request still present restarts from IDLE with a full latency.
// TESTING (DEPTH_LOG2=8, LATENCY=4 unless noted)
//  1. Store 0xDEADBEEF @0x10 at cycle 0 -> stall_o=1 cycles 0..4, ack_o=1 cycle 5, err_o=0;
//     then load @0x10 -> rdata_o=0xDEADBEEF in its ack cycle.
//  2. Load @0x13 (misaligned) -> stall 5 cycles, ack_o=err_o=1, rdata_o=0;
//     a follow-up load @0x10 still returns 0xDEADBEEF.
//  3. Store 0x12345678 @0x400, then load @0x000 -> rdata_o=0x12345678 (alias).
//  4. MemRead_i=MemWrite_i=1 @0x20, wdata=0xFFFFFFFF -> ack_o=err_o=1;
//     a later load @0x20 returns its prior value (0).
//  5. Assert rst_i in cycle 2 of a store @0x30 (0xAAAA5555) -> ack_o never pulses;
//     a later load @0x30 returns 0; all outputs 0 during reset.
//  6. LATENCY=1, three consecutive requests -> each stalls 2 cycles, acks 1 cycle apart from the
//     next stall, and no request completes twice.

Source files
------------

// File: rtl/data_mem_resp.sv
// Memory-stage responder: services one EX/MEM load/store against a word-addressed RAM
// with a fixed latency, stalling the pipeline until a single-cycle completion pulse.
module data_mem_resp #(
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        ack_o,
  output logic        err_o,
  output logic        stall_o
);

  localparam int AW = DEPTH_LOG2 + 2;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  rd_q, rd_d, wr_q, wr_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  req, stall_c, access, misaligned, conflict, ram_we;
  logic [DEPTH_LOG2-1:0] idx;

  logic [31:0] mem_q [0:(1<<DEPTH_LOG2)-1] = '{default: '0};

  // Upper address bits only select an alias of the same word.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr_i[31:AW];

  assign req        = MemRead_i | MemWrite_i;
  assign idx        = addr_q[AW-1:2];
  assign misaligned = addr_q[1:0] != 2'b00;
  assign conflict   = rd_q & wr_q;
  assign ram_we     = access & wr_q & ~rd_q & ~misaligned;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    stall_c = 1'b0;
    access  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          stall_c = 1'b1;
          state_d = WAIT;
          cnt_d   = 4'(LATENCY - 1);
          rd_d    = MemRead_i;
          wr_d    = MemWrite_i;
          addr_d  = addr_i[AW-1:0];
          wdata_d = wdata_i;
        end
      end
      WAIT: begin
        stall_c = 1'b1;
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          access  = 1'b1;
          state_d = DONE;
          if (rd_q && !wr_q) begin
            rdata_d = misaligned ? 32'd0 : mem_q[idx];
          end
        end
      end
      // The old request is still on the inputs here and must not retrigger.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clk_i) begin
    rd_q    <= rd_d;
    wr_q    <= wr_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    if (ram_we) begin
      mem_q[idx] <= wdata_q;
    end
  end

  assign rdata_o = rdata_q;
  assign ack_o   = state_q == DONE;
  assign err_o   = (state_q == DONE) & (misaligned | conflict);
  assign stall_o = stall_c & ~rst_i;

endmodule

// File: tb/tb_data_mem_resp.sv
// Directed bench for data_mem_resp: default instance (LATENCY=4) plus a LATENCY=1 instance.
module tb_data_mem_resp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd = 1'b0, wr = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata_o;
  logic        ack_o, err_o, stall_o;

  logic        rd1 = 1'b0, wr1 = 1'b0;
  logic [31:0] addr1 = '0, wdata1 = '0;
  logic [31:0] rdata1;
  logic        ack1, err1, stall1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  data_mem_resp u_dut (
    .clk_i(clk), .rst_i(rst), .MemRead_i(rd), .MemWrite_i(wr), .addr_i(addr),
    .wdata_i(wdata), .rdata_o(rdata_o), .ack_o(ack_o), .err_o(err_o), .stall_o(stall_o)
  );

  data_mem_resp #(.DEPTH_LOG2(8), .LATENCY(1)) u_lat1 (
    .clk_i(clk), .rst_i(rst), .MemRead_i(rd1), .MemWrite_i(wr1), .addr_i(addr1),
    .wdata_i(wdata1), .rdata_o(rdata1), .ack_o(ack1), .err_o(err1), .stall_o(stall1)
  );

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called just after a rising edge with the request on the inputs; returns one cycle after ack.
  task automatic wait_ack(input string tag, input logic exp_err, input logic chk,
                          input logic [31:0] exp_rd);
    int   cyc = 0;
    int   st  = 0;
    logic got = 1'b0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      if (ack_o) begin
        got = 1'b1;
        check32({tag, "_stall_in_ack"}, 32'(stall_o), 32'd0);
        check32({tag, "_err"}, 32'(err_o), 32'(exp_err));
        if (chk) check32({tag, "_rdata"}, rdata_o, exp_rd);
      end else begin
        cyc++;
        if (stall_o) st++;
      end
      @(posedge clk);
      #1;
    end
    check32({tag, "_acked"}, 32'(got), 32'd1);
    check32({tag, "_cycles"}, 32'(cyc), 32'd5);
    check32({tag, "_stalls"}, 32'(st), 32'd5);
  endtask

  task automatic mem_op(input string tag, input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic exp_err, input logic chk,
                        input logic [31:0] exp_rd);
    rd = r; wr = w; addr = a; wdata = d;
    wait_ack(tag, exp_err, chk, exp_rd);
    rd = 1'b0; wr = 1'b0;
  endtask

  initial begin
    logic [9:0] exp_st;
    logic [9:0] exp_ack;
    int         ack_seen;

    #3;
    check32("rst_rdata", rdata_o, 32'd0);
    check32("rst_ack", 32'(ack_o), 32'd0);
    check32("rst_err", 32'(err_o), 32'd0);
    check32("rst_stall", 32'(stall_o), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    mem_op("t1_store", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    check32("t1_idle_after", 32'({ack_o, stall_o}), 32'd0);
    @(posedge clk); #1;
    mem_op("t1_load", 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF);

    mem_op("t2_misload", 1'b1, 1'b0, 32'h13, 32'h0, 1'b1, 1'b1, 32'd0);
    mem_op("t2_load", 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF);
    mem_op("t2_misstore", 1'b0, 1'b1, 32'h11, 32'h0BAD0BAD, 1'b1, 1'b0, 32'd0);
    mem_op("t2_reload", 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF);

    mem_op("t3_store", 1'b0, 1'b1, 32'h400, 32'h12345678, 1'b0, 1'b0, 32'd0);
    mem_op("t3_alias", 1'b1, 1'b0, 32'h000, 32'h0, 1'b0, 1'b1, 32'h12345678);

    mem_op("t4_both", 1'b1, 1'b1, 32'h20, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h12345678);
    mem_op("t4_load", 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b1, 32'd0);

    // Store interrupted by reset in its third stall cycle; pipeline swaps in a load meanwhile.
    rd = 1'b0; wr = 1'b1; addr = 32'h30; wdata = 32'hAAAA5555;
    ack_seen = 0;
    @(negedge clk); if (ack_o) ack_seen++;
    @(negedge clk); if (ack_o) ack_seen++;
    @(posedge clk); #1;
    rst = 1'b1;
    #2;
    check32("t5_rst_rdata", rdata_o, 32'd0);
    check32("t5_rst_flags", 32'({ack_o, err_o, stall_o}), 32'd0);
    rd = 1'b1; wr = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ack_o) ack_seen++;
    end
    check32("t5_no_ack", 32'(ack_seen), 32'd0);
    check32("t5_rst_stall", 32'(stall_o), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    wait_ack("t5_restart", 1'b0, 1'b1, 32'd0);
    rd = 1'b0;

    // LATENCY=1 instance: three back-to-back requests, each held through its ack cycle.
    exp_st  = 10'b0011011011;
    exp_ack = 10'b0100100100;
    rd1 = 1'b0; wr1 = 1'b1; addr1 = 32'h0; wdata1 = 32'h11;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check32($sformatf("t6_stall_c%0d", c), 32'(stall1), 32'(exp_st[c]));
      check32($sformatf("t6_ack_c%0d", c), 32'(ack1), 32'(exp_ack[c]));
      if (c == 8) check32("t6_rdata", rdata1, 32'h11);
      if (ack1) check32($sformatf("t6_err_c%0d", c), 32'(err1), 32'd0);
      @(posedge clk); #1;
      if (c == 2) begin
        addr1 = 32'h4; wdata1 = 32'h22;
      end else if (c == 5) begin
        rd1 = 1'b1; wr1 = 1'b0; addr1 = 32'h0;
      end else if (c == 8) begin
        rd1 = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
